inst_profiler: RTL and testbench
================================

INST_PROFILER -- requirements
Module: inst_profiler

Interface
REQ-001 CNT_W, 16, width of each instruction-class counter.
REQ-002 DRAIN_CYC, 6, fill/drain cycles added to total clock estimates.
REQ-003 clk  input  1  core clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 retire_valid  input  1  one instruction retires this cycle.
REQ-006 retire_inst  input  32  retiring instruction word, opcode in [31:26].
REQ-007 stall_w_fwd  input  2  stall cycles charged this cycle with forwarding (0..3).
REQ-008 stall_wo_fwd  input  2  stall cycles charged this cycle without forwarding (0..3).
REQ-009 arith_inst_cnt, logic_inst_cnt, mem_inst_cnt, ctrl_inst_cnt  output  CNT_W each  class counts.
REQ-010 total_inst_cnt  output  32  sum of the four class counts.
REQ-011 stall_w_forewarding, stall_wo_forewarding  output  32 each  accumulated stalls.
REQ-012 total_clk_w_forwarding, total_clk_wo_forwarding  output  32 each  total_inst_cnt + DRAIN_CYC + respective stall sum.
REQ-013 halted  output  1  high once HALT retired and drain done; sticky until reset.
REQ-014 illegal_op  output  1  sticky, set on retire of an undefined opcode.

Function
REQ-015 Classification on retire_valid: arith = 000000..000101 (ADD,ADDI,SUB,SUBI,MUL,MULI); logic = 000110..001011 (OR..XORI); mem = 001100,001101 (LDW,STW); ctrl = 001110..010001 (BZ,BEQ,JR,HALT).
REQ-016 Opcode >= 010010 with retire_valid: no counter changes, illegal_op set next cycle.
REQ-017 Counters update on the clock edge following the retire cycle; outputs registered, latency 1 cycle.
REQ-018 Class counters saturate at 2^CNT_W-1; stall sums saturate at 2^32-1; no wrap.
REQ-019 total_inst_cnt and total_clk_* are combinational from registered counters, 32-bit, zero-extended operands.
REQ-020 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-021 IDLE -> RUN on first retire_valid; that retire is counted.
REQ-022 RUN -> DRAIN on retire_valid with opcode 010001; HALT counted as ctrl.
REQ-023 DRAIN counts DRAIN_CYC cycles via a down-counter, then -> DONE; halted asserts on entry to DONE.
REQ-024 In DRAIN and DONE, retire_valid and stall inputs are ignored; counters frozen.
REQ-025 Stall inputs accumulate in IDLE and RUN regardless of retire_valid, same edge as retire update.
REQ-026 Simultaneous retire and nonzero stall in one cycle: both applied on the same edge.
REQ-027 A second HALT while in DRAIN has no effect.

Reset
REQ-028 reset low at a rising edge: FSM -> IDLE, all counters, stall sums, drain counter, halted, illegal_op -> 0.
REQ-029 Reset mid-operation (any state) takes priority over every other update in that cycle.

Configuration
REQ-030 Macro INST_PROFILER_STALL_EN defined: stall inputs accumulate per REQ-025.
REQ-031 Macro undefined: stall sum registers absent, stall_* outputs tied 0, total_clk_* = total_inst_cnt + DRAIN_CYC, stall inputs unused.

Structure
REQ-032 Shared package holds opcode constants, inst_class_t enum (ARITH, LOGIC, MEM, CTRL, ILLEGAL) and prof_state_t FSM enum.
REQ-033 One sub-module inst_classifier: combinational opcode -> inst_class_t plus is_halt flag.

Verification
REQ-034 Reset low 2 cycles, release -> all outputs 0, halted=0, FSM IDLE.
REQ-035 Retire ADD, ORI, LDW, BEQ, MULI then HALT (010001) -> arith=2, logic=1, mem=1, ctrl=2, total=6, halted high exactly 7 cycles after HALT retire cycle.
REQ-036 With STALL_EN: 3 cycles stall_w_fwd=1, stall_wo_fwd=2 then HALT -> stall_w=3, stall_wo=6, total_clk_w=1+6+3=10, total_clk_wo=13.
REQ-037 Retire opcode 111111 -> illegal_op=1, all counts unchanged; retire ADD after -> arith=1.
REQ-038 Force arith_inst_cnt to 16'hFFFF, retire ADD -> stays 16'hFFFF; reset during DRAIN -> all 0, halted never asserts.

Source files
------------

// File: rtl/inst_profiler_pkg.sv
// inst_profiler_pkg: opcode boundaries, class/FSM enums and the saturating stall adder shared by the profiler.
package inst_profiler_pkg;
  localparam logic [5:0] OP_MULI = 6'b000101;
  localparam logic [5:0] OP_XORI = 6'b001011;
  localparam logic [5:0] OP_STW  = 6'b001101;
  localparam logic [5:0] OP_HALT = 6'b010001;
  typedef enum logic [2:0] {ARITH, LOGIC, MEM, CTRL, ILLEGAL} inst_class_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} prof_state_t;
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {31'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction
endpackage

// File: rtl/inst_profiler_classifier.sv
// inst_classifier: maps a 6-bit opcode to its instruction class and flags HALT.
module inst_classifier
  import inst_profiler_pkg::*;
(
  input  logic [5:0]  opcode,
  output inst_class_t inst_class,
  output logic        is_halt
);
  always_comb begin
    inst_class = opcode <= OP_MULI ? ARITH :
                 opcode <= OP_XORI ? LOGIC :
                 opcode <= OP_STW  ? MEM   :
                 opcode <= OP_HALT ? CTRL  : ILLEGAL;
    is_halt = opcode == OP_HALT;
  end
endmodule

// File: rtl/inst_profiler.sv
// inst_profiler: counts retired instructions per class, runs a HALT drain FSM and, with
// INST_PROFILER_STALL_EN defined, accumulates stall cycles into the total clock estimates.
module inst_profiler
  import inst_profiler_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int DRAIN_CYC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             retire_valid,
  input  logic [31:0]      retire_inst,
  input  logic [1:0]       stall_w_fwd,
  input  logic [1:0]       stall_wo_fwd,
  output logic [CNT_W-1:0] arith_inst_cnt,
  output logic [CNT_W-1:0] logic_inst_cnt,
  output logic [CNT_W-1:0] mem_inst_cnt,
  output logic [CNT_W-1:0] ctrl_inst_cnt,
  output logic [31:0]      total_inst_cnt,
  output logic [31:0]      stall_w_forewarding,
  output logic [31:0]      stall_wo_forewarding,
  output logic [31:0]      total_clk_w_forwarding,
  output logic [31:0]      total_clk_wo_forwarding,
  output logic             halted,
  output logic             illegal_op
);
  localparam int DW = $clog2(DRAIN_CYC + 1);
  prof_state_t state, next_state;
  inst_class_t inst_class;
  logic is_halt, active, ret, unused;
  logic [DW-1:0] drain_cnt, next_drain;
  logic [CNT_W-1:0] cnt [4];
  inst_classifier u_cls (.opcode(retire_inst[31:26]), .inst_class(inst_class), .is_halt(is_halt));
  assign active = state == IDLE || state == RUN;
  assign ret = active && retire_valid;
  always_comb begin
    next_state = state;
    next_drain = drain_cnt;
    case (state)
      IDLE, RUN: begin
        next_state = retire_valid ? (is_halt ? DRAIN : RUN) : state;
        next_drain = retire_valid && is_halt ? DW'(DRAIN_CYC - 1) : drain_cnt;
      end
      DRAIN: begin
        next_state = drain_cnt == '0 ? DONE : DRAIN;
        next_drain = drain_cnt == '0 ? drain_cnt : drain_cnt - DW'(1);
      end
      default: next_state = DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      drain_cnt  <= '0;
      illegal_op <= 1'b0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      state      <= next_state;
      drain_cnt  <= next_drain;
      illegal_op <= illegal_op | (ret && inst_class == ILLEGAL);
      if (ret && inst_class != ILLEGAL && cnt[inst_class[1:0]] != '1)
        cnt[inst_class[1:0]] <= cnt[inst_class[1:0]] + CNT_W'(1);
    end
  end
  assign arith_inst_cnt = cnt[0];
  assign logic_inst_cnt = cnt[1];
  assign mem_inst_cnt   = cnt[2];
  assign ctrl_inst_cnt  = cnt[3];
  assign halted         = state == DONE;
  assign total_inst_cnt = 32'(cnt[0]) + 32'(cnt[1]) + 32'(cnt[2]) + 32'(cnt[3]);
`ifdef INST_PROFILER_STALL_EN
  logic [31:0] stall_w_sum, stall_wo_sum;
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_w_sum  <= '0;
      stall_wo_sum <= '0;
    end else if (active) begin
      stall_w_sum  <= sat_add(stall_w_sum, stall_w_fwd);
      stall_wo_sum <= sat_add(stall_wo_sum, stall_wo_fwd);
    end
  end
  assign stall_w_forewarding  = stall_w_sum;
  assign stall_wo_forewarding = stall_wo_sum;
  assign unused = ^retire_inst[25:0];
`else
  assign stall_w_forewarding  = '0;
  assign stall_wo_forewarding = '0;
  assign unused = ^{retire_inst[25:0], stall_w_fwd, stall_wo_fwd};
`endif
  assign total_clk_w_forwarding  = total_inst_cnt + 32'(DRAIN_CYC) + stall_w_forewarding;
  assign total_clk_wo_forwarding = total_inst_cnt + 32'(DRAIN_CYC) + stall_wo_forewarding;
endmodule

// File: tb/tb_inst_profiler.sv
// tb_inst_profiler: directed self-checking bench for inst_profiler, valid with or without INST_PROFILER_STALL_EN.
module tb_inst_profiler;
`ifdef INST_PROFILER_STALL_EN
  localparam int SE = 1;
`else
  localparam int SE = 0;
`endif
  logic clk = 0, reset = 0, retire_valid = 0;
  logic [31:0] retire_inst = '0;
  logic [1:0] stall_w_fwd = '0, stall_wo_fwd = '0;
  logic [15:0] arith_inst_cnt, logic_inst_cnt, mem_inst_cnt, ctrl_inst_cnt;
  logic [31:0] total_inst_cnt, stall_w_forewarding, stall_wo_forewarding;
  logic [31:0] total_clk_w_forwarding, total_clk_wo_forwarding;
  logic halted, illegal_op;
  int n_chk = 0, n_fail = 0;
  inst_profiler dut (
    .clk(clk), .reset(reset), .retire_valid(retire_valid), .retire_inst(retire_inst),
    .stall_w_fwd(stall_w_fwd), .stall_wo_fwd(stall_wo_fwd),
    .arith_inst_cnt(arith_inst_cnt), .logic_inst_cnt(logic_inst_cnt),
    .mem_inst_cnt(mem_inst_cnt), .ctrl_inst_cnt(ctrl_inst_cnt),
    .total_inst_cnt(total_inst_cnt), .stall_w_forewarding(stall_w_forewarding),
    .stall_wo_forewarding(stall_wo_forewarding), .total_clk_w_forwarding(total_clk_w_forwarding),
    .total_clk_wo_forwarding(total_clk_wo_forwarding), .halted(halted), .illegal_op(illegal_op)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic retire(input logic [5:0] op);
    retire_valid = 1;
    retire_inst = {op, 26'h1555555};
    tick();
    retire_valid = 0;
  endtask
  task automatic cnts(input string tag, input int a, input int l, input int m, input int c, input int sw, input int swo);
    chk({tag, ".arith"}, 32'(arith_inst_cnt), a);
    chk({tag, ".logic"}, 32'(logic_inst_cnt), l);
    chk({tag, ".mem"}, 32'(mem_inst_cnt), m);
    chk({tag, ".ctrl"}, 32'(ctrl_inst_cnt), c);
    chk({tag, ".total"}, total_inst_cnt, a + l + m + c);
    chk({tag, ".stall_w"}, stall_w_forewarding, SE * sw);
    chk({tag, ".stall_wo"}, stall_wo_forewarding, SE * swo);
    chk({tag, ".clk_w"}, total_clk_w_forwarding, a + l + m + c + 6 + SE * sw);
    chk({tag, ".clk_wo"}, total_clk_wo_forwarding, a + l + m + c + 6 + SE * swo);
  endtask
  task automatic do_reset();
    reset = 0;
    tick();
    reset = 1;
  endtask
  initial begin
    int seen;
    #2;
    tick();
    tick();
    cnts("rst", 0, 0, 0, 0, 0, 0);
    chk("rst.halted", 32'(halted), 0);
    chk("rst.illegal", 32'(illegal_op), 0);
    reset = 1;
    // stalls accumulate while idle, then a lone HALT drains
    stall_w_fwd = 1;
    stall_wo_fwd = 2;
    tick();
    chk("stall1.w", stall_w_forewarding, SE * 1);
    tick();
    tick();
    stall_w_fwd = 0;
    stall_wo_fwd = 0;
    retire(6'h11);
    cnts("stall_halt", 0, 0, 0, 1, 3, 6);
    stall_w_fwd = 3;
    stall_wo_fwd = 3;
    retire(6'h11);
    retire(6'h00);
    stall_w_fwd = 0;
    stall_wo_fwd = 0;
    cnts("drain_frozen", 0, 0, 0, 1, 3, 6);
    do_reset();
    chk("rst2.halted", 32'(halted), 0);
    cnts("rst2", 0, 0, 0, 0, 0, 0);
    retire(6'h00);
    chk("add_latency.arith", 32'(arith_inst_cnt), 1);
    retire(6'h07);
    retire(6'h0C);
    retire(6'h0F);
    retire(6'h05);
    retire(6'h11);
    cnts("mix", 2, 1, 1, 2, 0, 0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (halted) seen++;
      tick();
    end
    chk("halt_early", seen, 0);
    tick();
    chk("halt_at7", 32'(halted), 1);
    retire(6'h00);
    cnts("done_frozen", 2, 1, 1, 2, 0, 0);
    chk("done_sticky", 32'(halted), 1);
    do_reset();
    retire(6'h3F);
    chk("ill.flag", 32'(illegal_op), 1);
    cnts("ill", 0, 0, 0, 0, 0, 0);
    stall_w_fwd = 2;
    stall_wo_fwd = 3;
    retire(6'h00);
    stall_w_fwd = 0;
    stall_wo_fwd = 0;
    cnts("ill_then_add_stall", 1, 0, 0, 0, 2, 3);
    chk("ill.sticky", 32'(illegal_op), 1);
    retire(6'h05);
    retire(6'h06);
    retire(6'h0B);
    retire(6'h0D);
    retire(6'h0E);
    retire(6'h10);
    retire(6'h12);
    cnts("bounds", 2, 2, 1, 2, 2, 3);
    do_reset();
    retire_valid = 1;
    retire_inst = {6'h00, 26'h0};
    for (int i = 0; i < 65535; i++) tick();
    cnts("sat_fill", 65535, 0, 0, 0, 0, 0);
    tick();
    retire_valid = 0;
    cnts("sat_hold", 65535, 0, 0, 0, 0, 0);
    retire(6'h11);
    tick();
    tick();
    do_reset();
    cnts("rst_drain", 0, 0, 0, 0, 0, 0);
    chk("rst_drain.halted", 32'(halted), 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (halted) seen++;
    end
    chk("no_halt_after_rst", seen, 0);
    retire(6'h00);
    chk("idle_after_rst.arith", 32'(arith_inst_cnt), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
